// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mult_div_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit (master) and the multiply/divide unit (slave).
interface mult_div_unit_if #(
  parameter int unsigned DATA_LEN = 32
) ();
  logic                start;
  logic [1:0]          op;
  logic [DATA_LEN-1:0] a;
  logic [DATA_LEN-1:0] b;
  logic                wr_hi;
  logic                wr_lo;
  logic [DATA_LEN-1:0] wdata;
  logic                busy;
  logic                done;
  logic                div_by_zero;
  logic [DATA_LEN-1:0] hi;
  logic [DATA_LEN-1:0] lo;

  modport master (
    output start, op, a, b, wr_hi, wr_lo, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, wr_hi, wr_lo, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit_md_step.sv
// One iteration of radix-2 shift-add multiply or restoring divide; purely combinational.
module md_step #(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                mode_i,  // 0: multiply step, 1: divide step
  input  logic [DATA_LEN:0]   rem_i,
  input  logic [DATA_LEN-1:0] quo_i,
  input  logic [DATA_LEN-1:0] b_i,
  output logic [DATA_LEN:0]   rem_o,
  output logic [DATA_LEN-1:0] quo_o
);

  logic [DATA_LEN:0]   sum;
  logic [DATA_LEN+1:0] shifted;
  logic [DATA_LEN+1:0] trial;

  // Multiply: {rem, quo} holds {partial product, remaining multiplier bits}.
  // Divide: rem is the partial remainder, quo shifts dividend bits out and quotient bits in.
  always_comb begin
    sum     = '0;
    shifted = '0;
    trial   = '0;
    rem_o   = rem_i;
    quo_o   = quo_i;
    if (!mode_i) begin
      sum   = rem_i + (quo_i[0] ? {1'b0, b_i} : '0);
      rem_o = {1'b0, sum[DATA_LEN:1]};
      quo_o = {sum[0], quo_i[DATA_LEN-1:1]};
    end else begin
      shifted = {rem_i, quo_i[DATA_LEN-1]};
      trial   = shifted - {2'b00, b_i};
      if (trial[DATA_LEN+1]) begin
        // Borrow: keep the shifted remainder, quotient bit 0.
        rem_o = shifted[DATA_LEN:0];
        quo_o = {quo_i[DATA_LEN-2:0], 1'b0};
      end else begin
        rem_o = trial[DATA_LEN:0];
        quo_o = {quo_i[DATA_LEN-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32
) (
  input logic             clk,
  input logic             rst,
  mult_div_unit_if.slave  bus
);

  localparam int unsigned CntW = $clog2(DATA_LEN);

  state_t              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_LEN:0]   rem_q, rem_d;
  logic [DATA_LEN-1:0] quo_q, quo_d;
  logic [DATA_LEN-1:0] b_q, b_d;
  logic [DATA_LEN-1:0] a_raw_q, a_raw_d;
  logic [DATA_LEN-1:0] hi_q, hi_d;
  logic [DATA_LEN-1:0] lo_q, lo_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                b_zero_q, b_zero_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;

  logic                  in_signed, sign_a, sign_b;
  logic [DATA_LEN-1:0]   mag_a, mag_b;
  logic                  is_div;
  logic [DATA_LEN:0]     step_rem;
  logic [DATA_LEN-1:0]   step_quo;
  logic [2*DATA_LEN-1:0] prod, prod_fix;
  logic [DATA_LEN-1:0]   rem_mag, rem_fix, quo_fix;
  logic [DATA_LEN-1:0]   res_hi, res_lo;

  md_step #(
    .DATA_LEN (DATA_LEN)
  ) u_step (
    .mode_i (is_div),
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .b_i    (b_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  // Operand magnitudes and sign flags for the incoming request.
  always_comb begin
    in_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    sign_a    = in_signed & bus.a[DATA_LEN-1];
    sign_b    = in_signed & bus.b[DATA_LEN-1];
    mag_a     = sign_a ? -bus.a : bus.a;
    mag_b     = sign_b ? -bus.b : bus.b;
  end

  // Sign fix-up and divide-by-zero override applied in FIX.
  always_comb begin
    is_div   = (op_q == OP_DIVU) || (op_q == OP_DIV);
    prod     = {rem_q[DATA_LEN-1:0], quo_q};
    prod_fix = neg_res_q ? -prod : prod;
    rem_mag  = rem_q[DATA_LEN-1:0];
    rem_fix  = neg_rem_q ? -rem_mag : rem_mag;
    quo_fix  = neg_res_q ? -quo_q : quo_q;
    if (!is_div) begin
      res_hi = prod_fix[2*DATA_LEN-1:DATA_LEN];
      res_lo = prod_fix[DATA_LEN-1:0];
    end else if (b_zero_q) begin
      res_hi = a_raw_q;
      res_lo = '1;
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: CALC lasts exactly DATA_LEN cycles, FIX one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (cnt_q == CntW'(DATA_LEN - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and result registers.
  always_comb begin
    bus.busy        = (state_q != IDLE);
    bus.done        = done_q;
    bus.div_by_zero = dbz_q;
    bus.hi          = hi_q;
    bus.lo          = lo_q;
  end

  // Datapath next-state: capture, iterate, write back.
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    b_d       = b_q;
    a_raw_d   = a_raw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    b_zero_d  = b_zero_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.wr_hi) hi_d = bus.wdata;
        if (bus.wr_lo) lo_d = bus.wdata;
        if (bus.start) begin
          op_d      = bus.op;
          a_raw_d   = bus.a;
          quo_d     = mag_a;
          b_d       = mag_b;
          rem_d     = '0;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          b_zero_d  = (bus.b == '0);
          cnt_d     = '0;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CntW'(1);
      end
      FIX: begin
        hi_d   = res_hi;
        lo_d   = res_lo;
        done_d = 1'b1;
        dbz_d  = is_div & b_zero_q;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      b_q       <= '0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      b_q       <= b_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      b_zero_q  <= b_zero_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed DATA_LEN=8 scenarios plus a DATA_LEN=32 random regression against an arithmetic model.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  mult_div_unit_if #(.DATA_LEN(8))  if8 ();
  mult_div_unit_if #(.DATA_LEN(32)) if32 ();

  mult_div_unit #(.DATA_LEN(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  mult_div_unit #(.DATA_LEN(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on dl-bit operands.
  function automatic void model(input int dl, input logic [1:0] op, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] hi,
                                output logic [63:0] lo, output logic dbz);
    logic [63:0] mask;
    logic [63:0] p;
    longint      sa, sb, q, r;
    mask = (64'd1 << dl) - 64'd1;
    sa   = a[dl-1] ? longint'(a) - longint'(64'd1 << dl) : longint'(a);
    sb   = b[dl-1] ? longint'(b) - longint'(64'd1 << dl) : longint'(b);
    dbz  = 1'b0;
    hi   = '0;
    lo   = '0;
    case (op)
      OP_MULTU: begin
        p  = a * b;
        hi = (p >> dl) & mask;
        lo = p & mask;
      end
      OP_MULT: begin
        p  = 64'(sa * sb);
        hi = (p >> dl) & mask;
        lo = p & mask;
      end
      default: begin
        if (b == 64'd0) begin
          dbz = 1'b1;
          lo  = mask;
          hi  = a;
        end else if (op == OP_DIVU) begin
          lo = a / b;
          hi = a % b;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          lo = 64'(q) & mask;
          hi = 64'(r) & mask;
        end
      end
    endcase
  endfunction

  // Called at a negedge: present a request, return at the negedge after the accepting edge.
  task automatic launch8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if8.start = 1'b1;
    if8.op    = op;
    if8.a     = a;
    if8.b     = b;
    @(negedge clk);
    if8.start = 1'b0;
  endtask

  // Counts cycles from the accepting edge until done is seen (bounded).
  task automatic wait_done8(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!if8.done && lat < 40) begin
      if (if8.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op8(input string tag, input logic [1:0] op, input logic [7:0] a,
                     input logic [7:0] b);
    int lat, bcnt;
    logic [63:0] ehi, elo;
    logic edbz;
    model(8, op, 64'(a), 64'(b), ehi, elo, edbz);
    launch8(op, a, b);
    wait_done8(lat, bcnt);
    chk({tag, "_lat"}, 64'(lat), 64'd9);
    chk({tag, "_hi"}, 64'(if8.hi), ehi);
    chk({tag, "_lo"}, 64'(if8.lo), elo);
    chk({tag, "_dbz"}, 64'(if8.div_by_zero), 64'(edbz));
  endtask

  task automatic op32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [63:0] ehi, elo;
    logic edbz;
    model(32, op, 64'(a), 64'(b), ehi, elo, edbz);
    if32.start = 1'b1;
    if32.op    = op;
    if32.a     = a;
    if32.b     = b;
    @(negedge clk);
    if32.start = 1'b0;
    lat = 0;
    while (!if32.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("r32_lat", 64'(lat), 64'd33);
    chk("r32_hi", 64'(if32.hi), ehi);
    chk("r32_lo", 64'(if32.lo), elo);
    chk("r32_dbz", 64'(if32.div_by_zero), 64'(edbz));
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int lat, bcnt, extra;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    {if8.start, if8.op, if8.a, if8.b, if8.wr_hi, if8.wr_lo, if8.wdata} = '0;
    {if32.start, if32.op, if32.a, if32.b, if32.wr_hi, if32.wr_lo, if32.wdata} = '0;

    #12;
    chk("rst_hi", 64'(if8.hi), 64'd0);
    chk("rst_lo", 64'(if8.lo), 64'd0);
    chk("rst_busy", 64'(if8.busy), 64'd0);
    chk("rst_done", 64'(if8.done), 64'd0);
    chk("rst_dbz", 64'(if8.div_by_zero), 64'd0);
    chk("rst_hi32", 64'(if32.hi), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // MULTU with busy-length check; the remaining ops are issued in each done cycle.
    launch8(OP_MULTU, 8'd200, 8'd150);
    wait_done8(lat, bcnt);
    chk("multu_lat", 64'(lat), 64'd9);
    chk("multu_busy", 64'(bcnt), 64'd9);
    chk("multu_busy_low", 64'(if8.busy), 64'd0);
    chk("multu_hi", 64'(if8.hi), 64'h75);
    chk("multu_lo", 64'(if8.lo), 64'h30);
    op8("mult", OP_MULT, 8'hFD, 8'h07);
    chk("mult_hi_c", 64'(if8.hi), 64'hFF);
    chk("mult_lo_c", 64'(if8.lo), 64'hEB);
    op8("div", OP_DIV, 8'hF9, 8'h02);
    chk("div_lo_c", 64'(if8.lo), 64'hFD);
    chk("div_hi_c", 64'(if8.hi), 64'hFF);
    op8("divu", OP_DIVU, 8'hF9, 8'h02);
    chk("divu_lo_c", 64'(if8.lo), 64'h7C);
    chk("divu_hi_c", 64'(if8.hi), 64'h01);
    op8("divu0", OP_DIVU, 8'h5A, 8'h00);
    chk("divu0_lo_c", 64'(if8.lo), 64'hFF);
    chk("divu0_hi_c", 64'(if8.hi), 64'h5A);
    chk("divu0_dbz_c", 64'(if8.div_by_zero), 64'd1);
    op8("div0", OP_DIV, 8'hF9, 8'h00);
    op8("divovf", OP_DIV, 8'h80, 8'hFF);
    chk("divovf_lo_c", 64'(if8.lo), 64'h80);
    chk("divovf_hi_c", 64'(if8.hi), 64'h00);
    op8("mult_min", OP_MULT, 8'h80, 8'h80);
    op8("div_mix", OP_DIV, 8'h07, 8'hFE);
    @(negedge clk);
    chk("done_single", 64'(if8.done), 64'd0);
    chk("dbz_single", 64'(if8.div_by_zero), 64'd0);

    // start pulsed mid-CALC, with different operands, must not disturb the running op.
    launch8(OP_MULTU, 8'd12, 8'd11);
    repeat (3) @(negedge clk);
    launch8(OP_DIV, 8'hFF, 8'hFF);
    lat = 4;
    while (!if8.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("mid_lat", 64'(lat), 64'd9);
    chk("mid_hi", 64'(if8.hi), 64'h00);
    chk("mid_lo", 64'(if8.lo), 64'h84);
    @(negedge clk);
    extra = 0;
    repeat (12) begin
      if (if8.done || if8.busy) extra++;
      @(negedge clk);
    end
    chk("mid_no_second", 64'(extra), 64'd0);

    // MTHI/MTLO in IDLE.
    if8.wr_hi = 1'b1;
    if8.wdata = 8'h3C;
    @(negedge clk);
    if8.wr_hi = 1'b0;
    chk("mthi_idle", 64'(if8.hi), 64'h3C);

    // MTHI while busy is ignored.
    launch8(OP_MULTU, 8'd3, 8'd5);
    if8.wr_hi = 1'b1;
    if8.wdata = 8'hAA;
    @(negedge clk);
    if8.wr_hi = 1'b0;
    chk("mthi_busy", 64'(if8.hi), 64'h3C);
    wait_done8(lat, bcnt);
    chk("mthi_busy_hi", 64'(if8.hi), 64'h00);
    chk("mthi_busy_lo", 64'(if8.lo), 64'h0F);

    // MTLO together with start: both take effect, result later wins.
    if8.wr_lo = 1'b1;
    if8.wdata = 8'h55;
    launch8(OP_DIVU, 8'd100, 8'd7);
    if8.wr_lo = 1'b0;
    chk("mtlo_start", 64'(if8.lo), 64'h55);
    wait_done8(lat, bcnt);
    chk("mtlo_start_lo", 64'(if8.lo), 64'd14);
    chk("mtlo_start_hi", 64'(if8.hi), 64'd2);

    // Asynchronous reset mid-operation.
    launch8(OP_DIVU, 8'hF9, 8'h02);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_hi", 64'(if8.hi), 64'h00);
    chk("arst_lo", 64'(if8.lo), 64'h00);
    chk("arst_busy", 64'(if8.busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (12) begin
      if (if8.done || if8.busy) extra++;
      @(negedge clk);
    end
    chk("arst_no_done", 64'(extra), 64'd0);

    // DATA_LEN=32 random regression.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 250; i++) begin
        op32(2'(t), pick32(), pick32());
      end
    end
    op32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    op32(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    op32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
